fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Drives the consuming side of the program counter interface: fetches the instruction at the current pc over a req/ack instruction-memory port, then hands it downstream with a valid/ready handshake.
- Resolves control flow (J/JAL, JR/JALR, BEQ/BNE/BLEZ/BGTZ) from register-file data and returns a one-cycle pc_step strobe with pc_control, jump_address, branch_offset and reg_address to the PC register.
- Sits between the PC register, instruction memory, register file read ports and the decode stage. The PC register updates only on pc_step.

Parameters:
- ADDR_W, 32, width of pc / imem_addr / reg_address
- DATA_W, 32, instruction and register data width

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- pc  input  32  current program counter
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- rs_addr  output  5  register-file read address A = ir[25:21]
- rt_addr  output  5  register-file read address B = ir[20:16]
- rs_data  input  32  asynchronous read data A
- rt_data  input  32  asynchronous read data B
- instr  output  32  held instruction (ir)
- instr_valid  output  1  instr valid to decode
- instr_ready  input  1  decode accepts instr
- pc_step  output  1  one-cycle strobe: PC register loads next value
- pc_control  output  3  000 seq, 001 jump, 010 register, 011 branch
- jump_address  output  26  ir[25:0]
- branch_offset  output  16  ir[15:0]
- reg_address  output  32  rs_data captured for JR/JALR

Behaviour:
- FSM states: FETCH, ISSUE, STEP. Reset state is FETCH.
- Reset values: all outputs 0, ir=0.
- FETCH:
  - imem_req=1, imem_addr=pc (combinational).
  - On imem_ack: ir<=imem_rdata, go to ISSUE.
  - An ack in the same cycle as the first req is legal.
- ISSUE:
  - imem_req=0, instr_valid=1, instr=ir stable.
  - rs_addr/rt_addr driven from ir in all states.
  - When instr_valid&&instr_ready, resolve using rs_data/rt_data sampled that cycle and register the results:
    - opcode 000010/000011 -> pc_control=001.
    - opcode 000000 with funct 001000/001001 -> pc_control=010, reg_address<=rs_data.
    - 000100 (rs==rt), 000101 (rs!=rt), 000110 (signed rs<=0), 000111 (signed rs>0): taken -> 011, not taken -> 000.
    - Any other opcode -> 000.
  - jump_address<=ir[25:0] and branch_offset<=ir[15:0] always.
  - Go to STEP.
- STEP: pc_step=1 for exactly one cycle, instr_valid=0; then FETCH.
- Latency: ack in cycle N -> instr_valid in N+1 -> if ready, pc_step in N+2 -> imem_req with updated pc in N+3. Minimum 3 cycles per instruction.
- instr_ready low holds ISSUE indefinitely; no outputs change.
- imem_ack outside FETCH is ignored.
- pc_control is held between pc_step pulses and is meaningful only with pc_step.
- rst mid-operation: immediate return to FETCH; instr_valid and pc_step drop the same cycle; in-flight fetch abandoned.
- Hazard/forwarding on rs_data/rt_data is the register-file side's responsibility.

Decomposition:
- Shared package:
  - pc_control encodings (PC_SEQ=3'b000, PC_JUMP=3'b001, PC_REG=3'b010, PC_BRANCH=3'b011).
  - Opcode/funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, FN_JR, FN_JALR).
  - FSM state encodings.
- One natural sub-module: branch_resolve, combinational (ir, rs_data, rt_data -> pc_control).

Test Plan:
- Reset then release, imem_ack=1 with imem_rdata=0x00000020 (ADD), ready=1 -> instr_valid at +1, pc_step at +2 with pc_control=000.
- Fetch 0x08000040 (J) -> pc_control=001, jump_address=0x0000040.
- Fetch 0x10220003 (BEQ r1,r2,+3):
  - rs=rt=5 -> 011, branch_offset=0x0003.
  - rs=5, rt=6 -> 000.
- Fetch 0x1C200000 (BGTZ r1):
  - rs_data=0xFFFFFFFF -> 000.
  - rs_data=1 -> 011.
- Fetch 0x03E00008 (JR r31) with rs_data=0x00400100 -> pc_control=010, reg_address=0x00400100.
- Hold instr_ready=0 for 10 cycles -> instr stable, no pc_step. Assert rst mid-ISSUE -> instr_valid=0 immediately, imem_req=1 the cycle after release.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared encodings for the fetch sequencer and its branch resolver.
package fetch_sequencer_pkg;
  localparam logic [2:0] PC_SEQ    = 3'b000;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_REG    = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_STEP} state_e;
endpackage

// File: rtl/fetch_sequencer_branch_resolve.sv
// branch_resolve: combinational control-flow decision for the held instruction.
module branch_resolve
  import fetch_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [2:0]        pc_control
);
  logic [5:0] op, fn;
  logic eq, lez, taken;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign eq = rs_data == rt_data;
  assign lez = $signed(rs_data) <= 0;
  assign taken = (op == OP_BEQ && eq) || (op == OP_BNE && !eq) ||
                 (op == OP_BLEZ && lez) || (op == OP_BGTZ && !lez);
  assign pc_control = (op == OP_J || op == OP_JAL) ? PC_JUMP :
                      (op == OP_RTYPE && (fn == FN_JR || fn == FN_JALR)) ? PC_REG :
                      taken ? PC_BRANCH : PC_SEQ;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches at pc, hands the instruction to decode, then strobes the PC register
// with the resolved control-flow decision.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              pc_step,
  output logic [2:0]        pc_control,
  output logic [25:0]       jump_address,
  output logic [15:0]       branch_offset,
  output logic [ADDR_W-1:0] reg_address
);
  state_e state, state_next;
  logic [DATA_W-1:0] ir;
  logic [2:0] ctrl;
  branch_resolve #(.DATA_W(DATA_W)) u_resolve (
    .ir(ir), .rs_data(rs_data), .rt_data(rt_data), .pc_control(ctrl)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FETCH;
    else state <= state_next;
  // imem_req is gated by rst so every output reads 0 while reset is held.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = imem_ack ? S_ISSUE : S_FETCH;
      S_ISSUE: state_next = instr_ready ? S_STEP : S_ISSUE;
      default: state_next = S_FETCH;
    endcase
    imem_req = !rst && state == S_FETCH;
    imem_addr = imem_req ? pc : '0;
    instr_valid = state == S_ISSUE;
    pc_step = state == S_STEP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir <= '0;
      pc_control <= PC_SEQ;
      jump_address <= '0;
      branch_offset <= '0;
      reg_address <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (state == S_ISSUE && instr_ready) begin
        pc_control <= ctrl;
        jump_address <= ir[25:0];
        branch_offset <= ir[15:0];
        if (ctrl == PC_REG) reg_address <= ADDR_W'(rs_data);
      end
    end
  assign instr = ir;
  assign rs_addr = ir[25:21];
  assign rt_addr = ir[20:16];
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized instruction stream checked against a behavioural PC model.
module tb_fetch_sequencer;
  logic clk = 0, rst = 1;
  logic [31:0] pc = 32'h0040_0000;
  logic imem_req, imem_ack = 0, instr_valid, instr_ready = 0, pc_step;
  logic [31:0] imem_addr, imem_rdata = 0, rs_data = 0, rt_data = 0, instr, reg_address;
  logic [4:0] rs_addr, rt_addr;
  logic [2:0] pc_control;
  logic [25:0] jump_address;
  logic [15:0] branch_offset;
  int checks = 0, errors = 0;
  logic [31:0] exp_reg = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_step(pc_step), .pc_control(pc_control),
    .jump_address(jump_address), .branch_offset(branch_offset), .reg_address(reg_address)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_ctrl(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    int op;
    op = int'(w[31:26]);
    case (op)
      2, 3: return 3'd1;
      0: return (w[5:0] == 6'd8 || w[5:0] == 6'd9) ? 3'd2 : 3'd0;
      4: return (a == b) ? 3'd3 : 3'd0;
      5: return (a != b) ? 3'd3 : 3'd0;
      6: return ($signed(a) <= 0) ? 3'd3 : 3'd0;
      7: return ($signed(a) > 0) ? 3'd3 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  task automatic run(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                     input int ack_dly, input int stall);
    logic [2:0] ec;
    logic [31:0] seq;
    for (int i = 0; i < ack_dly; i++) begin
      chk("req_wait", 32'(imem_req), 1);
      tick();
    end
    chk("imem_req", 32'(imem_req), 1);
    chk("imem_addr", imem_addr, pc);
    imem_ack = 1;
    imem_rdata = w;
    tick();
    imem_ack = 0;
    imem_rdata = $urandom;
    chk("valid", 32'(instr_valid), 1);
    chk("instr", instr, w);
    chk("rs_addr", 32'(rs_addr), 32'(w[25:21]));
    chk("rt_addr", 32'(rt_addr), 32'(w[20:16]));
    chk("req_issue", 32'(imem_req), 0);
    rs_data = a;
    rt_data = b;
    for (int i = 0; i < stall; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", instr, w);
      chk("stall_step", 32'(pc_step), 0);
    end
    imem_ack = 0;
    instr_ready = 1;
    tick();
    instr_ready = 0;
    ec = ref_ctrl(w, a, b);
    if (ec == 3'd2) exp_reg = a;
    chk("pc_step", 32'(pc_step), 1);
    chk("step_valid", 32'(instr_valid), 0);
    chk("pc_control", 32'(pc_control), 32'(ec));
    chk("jump_address", 32'(jump_address), 32'(w[25:0]));
    chk("branch_offset", 32'(branch_offset), 32'(w[15:0]));
    chk("reg_address", reg_address, exp_reg);
    seq = pc + 4;
    case (ec)
      3'd1: pc = {seq[31:28], w[25:0], 2'b00};
      3'd2: pc = exp_reg;
      3'd3: pc = seq + {{14{w[15]}}, w[15:0], 2'b00};
      default: pc = seq;
    endcase
    tick();
    chk("step_once", 32'(pc_step), 0);
    chk("refetch_req", 32'(imem_req), 1);
    chk("refetch_addr", imem_addr, pc);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w = {6'd0, w[25:6], 6'h20};
      1: w[31:26] = 6'd2;
      2: w[31:26] = 6'd3;
      3: w = {6'd0, w[25:6], 6'd8};
      4: w = {6'd0, w[25:6], 6'd9};
      5: w[31:26] = 6'd4;
      6: w[31:26] = 6'd5;
      7: w[31:26] = 6'd6;
      8: w[31:26] = 6'd7;
      default: w[31:26] = 6'h23;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_step", 32'(pc_step), 0);
    chk("rst_ctrl", 32'(pc_control), 0);
    chk("rst_instr", instr, 0);
    chk("rst_reg", reg_address, 0);
    rst = 0;
    #1;
    run(32'h0000_0020, 0, 0, 0, 0);
    run(32'h0800_0040, 0, 0, 1, 0);
    run(32'h1022_0003, 5, 5, 0, 0);
    run(32'h1022_0003, 5, 6, 0, 1);
    run(32'h1C20_0000, 32'hFFFF_FFFF, 0, 2, 0);
    run(32'h1C20_0000, 1, 0, 0, 0);
    run(32'h03E0_0008, 32'h0040_0100, 0, 0, 2);
    for (int n = 0; n < 40; n++) begin
      a = rnd_data();
      b = ($urandom_range(0, 2) == 0) ? a : rnd_data();
      run(rnd_word(), a, b, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    imem_ack = 1;
    imem_rdata = 32'h1022_0003;
    tick();
    imem_ack = 0;
    for (int i = 0; i < 10; i++) begin
      imem_rdata = $urandom;
      tick();
      chk("hold_valid", 32'(instr_valid), 1);
      chk("hold_instr", instr, 32'h1022_0003);
      chk("hold_step", 32'(pc_step), 0);
    end
    rst = 1;
    #1;
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_step", 32'(pc_step), 0);
    chk("midrst_req", 32'(imem_req), 0);
    chk("midrst_instr", instr, 0);
    tick();
    rst = 0;
    exp_reg = 0;
    tick();
    chk("postrst_req", 32'(imem_req), 1);
    chk("postrst_addr", imem_addr, pc);
    for (int n = 0; n < 5; n++) begin
      a = rnd_data();
      b = rnd_data();
      run(rnd_word(), a, b, $urandom_range(0, 2), $urandom_range(0, 1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
